piso_tx_sched: RTL

Two-requester scheduler that shares one `piso_4bit` parallel-in/serial-out left-shift register.
- Arbitrates round-robin between two parallel-word sources, each with a valid/ready handshake.
- Drives the shift register's `load` and `parallel_in`, counts shifted bits, and flags which serial-line cycles carry valid data.
- Sits between packet sources and the serial output stage; bit order is MSB-first.

---
 rtl/piso_pkg.sv | 6 +
 rtl/piso_4bit.sv | 12 +
 rtl/rr_arb2.sv | 14 +
 rtl/piso_tx_sched.sv | 78 +++++++
 4 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: shared scheduler state encoding and width constants.
package piso_pkg;
   localparam int DEF_WIDTH = 4;
   localparam int CW = $clog2(DEF_WIDTH);
   typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
endpackage

// File: rtl/piso_4bit.sv
// piso_4bit: 4-bit parallel-in/serial-out left-shift register, MSB first.
module piso_4bit (
   input  logic       clk,
   input  logic       load,
   input  logic [3:0] parallel_in,
   output logic       serial_out
);
   logic [3:0] sr;
   always_ff @(posedge clk)
      sr <= load ? parallel_in : sr << 1;
   assign serial_out = sr[3];
endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; pointer holds the last grantee.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant
);
   logic ptr;
   always_comb grant = (req == 2'b11) ? (ptr ? 2'b01 : 2'b10) : req;
   always_ff @(posedge clk)
      if (rst) ptr <= 1'b1;
      else if (accept && |req) ptr <= grant[1];
endmodule

// File: rtl/piso_tx_sched.sv
// piso_tx_sched: round-robin scheduler feeding a shared PISO shift register.
// Optional trailing even-parity cycle per frame: PISO_TX_SCHED_PARITY_EN.
module piso_tx_sched
   import piso_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   input  logic [WIDTH-1:0] req_data0,
   input  logic [WIDTH-1:0] req_data1,
   output logic [1:0]       req_ready,
   output logic             piso_load,
   output logic [WIDTH-1:0] piso_data,
   output logic             bit_valid,
   output logic             frame_start,
   output logic             frame_last,
   output logic             grant_id,
   output logic             busy,
   output logic             par_sel,
   output logic             par_bit
);
   state_t        state, state_nxt;
   logic [CW-1:0] bit_cnt;
   logic [1:0]    grant;
   logic          last, open, accept;
   assign last = state == SHIFT && bit_cnt == CW'(WIDTH - 1);
`ifdef PISO_TX_SCHED_PARITY_EN
   logic par_q;
   assign open = state == IDLE || state == PAR;
`else
   assign open = state == IDLE || last;
`endif
   // accept is gated by rst so no word is lost to a reset edge
   assign accept = open && !rst && |req_valid;
   rr_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (req_valid),
      .accept(accept),
      .grant (grant)
   );
   always_comb begin
      req_ready   = accept ? grant : 2'b00;
      piso_load   = accept;
      piso_data   = !accept ? '0 : grant[1] ? req_data1 : req_data0;
      bit_valid   = state != IDLE;
      busy        = state != IDLE;
      frame_start = state == SHIFT && bit_cnt == '0;
`ifdef PISO_TX_SCHED_PARITY_EN
      frame_last  = state == PAR;
      par_sel     = state == PAR;
      par_bit     = par_q;
      state_nxt   = accept ? SHIFT : state == SHIFT ? (last ? PAR : SHIFT) : IDLE;
`else
      frame_last  = last;
      par_sel     = 1'b0;
      par_bit     = 1'b0;
      state_nxt   = accept ? SHIFT : (state == SHIFT && !last) ? SHIFT : IDLE;
`endif
   end
   always_ff @(posedge clk)
      if (rst) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         grant_id <= 1'b0;
      end else begin
         state   <= state_nxt;
         bit_cnt <= (state == SHIFT && !last) ? bit_cnt + 1'b1 : '0;
         if (accept) grant_id <= grant[1];
      end
`ifdef PISO_TX_SCHED_PARITY_EN
   always_ff @(posedge clk)
      if (rst) par_q <= 1'b0;
      else if (accept) par_q <= ^piso_data;
`endif
endmodule
